// File: rtl/crush_wb_pkg.sv
// ============================================================================
//  Module   : crush_wb_pkg
//  Purpose  : Shared Wishbone bus widths, master state encoding and helpers.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package crush_wb_pkg;

   localparam int WB_ADR_W = 32;
   localparam int WB_DAT_W = 32;
   localparam int WB_SEL_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      BACKOFF = 2'd2
   } wb_master_state_t;

   // Bits needed to hold the values 0..n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_timeout_counter.sv
// ============================================================================
//  Module   : wb_timeout_counter
//  Purpose  : Per-attempt cycle counter; flags the last permitted cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_timeout_counter
   import crush_wb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int                 c_CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;

   // Holds at the terminal value so expired stays asserted until cleared.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_cnt <= '0;
      end else if (enable_i && (r_cnt != c_LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign expired_o = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/wishbone_master.sv
// ============================================================================
//  Module   : wishbone_master
//  Purpose  : Single-outstanding Wishbone classic master with retry/timeout.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module wishbone_master
   import crush_wb_pkg::*;
#(
   parameter int MAX_RETRIES    = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_we_i,
   input  logic [WB_ADR_W-1:0] req_adr_i,
   input  logic [WB_SEL_W-1:0] req_sel_i,
   input  logic [WB_DAT_W-1:0] req_dat_i,
   output logic                rsp_valid_o,
   output logic [WB_DAT_W-1:0] rsp_dat_o,
   output logic                rsp_err_o,
   output logic                cyc_o,
   output logic                stb_o,
   output logic [WB_ADR_W-1:0] adr_o,
   output logic [WB_SEL_W-1:0] sel_o,
   output logic [WB_DAT_W-1:0] dat_o,
   output logic                we_o,
   input  logic [WB_DAT_W-1:0] dat_i,
   input  logic                ack_i,
   input  logic                err_i,
   input  logic                rty_i
);

   localparam int                 c_RTY_W   = cnt_width(MAX_RETRIES);
   localparam logic [c_RTY_W-1:0] c_MAX_RTY = c_RTY_W'(MAX_RETRIES);

   wb_master_state_t    r_state,     w_state_nxt;
   logic                r_cyc,       w_cyc_nxt;
   logic                r_stb,       w_stb_nxt;
   logic [WB_ADR_W-1:0] r_adr,       w_adr_nxt;
   logic [WB_SEL_W-1:0] r_sel,       w_sel_nxt;
   logic [WB_DAT_W-1:0] r_dat,       w_dat_nxt;
   logic                r_we,        w_we_nxt;
   logic                r_rsp_valid, w_rsp_valid_nxt;
   logic                r_rsp_err,   w_rsp_err_nxt;
   logic [WB_DAT_W-1:0] r_rsp_dat,   w_rsp_dat_nxt;
   logic [c_RTY_W-1:0]  r_retry,     w_retry_nxt;

   logic w_tmo_clear;
   logic w_tmo_enable;
   logic w_tmo_expired;
   logic w_done;
   logic w_done_err;
   logic w_capture;

   wb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (w_tmo_clear),
      .enable_i  (w_tmo_enable),
      .expired_o (w_tmo_expired)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_cyc_nxt       = r_cyc;
      w_stb_nxt       = r_stb;
      w_adr_nxt       = r_adr;
      w_sel_nxt       = r_sel;
      w_dat_nxt       = r_dat;
      w_we_nxt        = r_we;
      w_rsp_valid_nxt = 1'b0;
      w_rsp_err_nxt   = r_rsp_err;
      w_rsp_dat_nxt   = r_rsp_dat;
      w_retry_nxt     = r_retry;
      w_tmo_clear     = 1'b0;
      w_tmo_enable    = 1'b0;
      w_done          = 1'b0;
      w_done_err      = 1'b0;
      w_capture       = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               w_adr_nxt   = req_adr_i;
               w_sel_nxt   = req_sel_i;
               w_we_nxt    = req_we_i;
               w_dat_nxt   = req_we_i ? req_dat_i : '0;
               w_cyc_nxt   = 1'b1;
               w_stb_nxt   = 1'b1;
               w_retry_nxt = '0;
               w_tmo_clear = 1'b1;
               w_state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            // Termination priority: ack, err, rty, then the attempt timeout.
            if (ack_i) begin
               w_done    = 1'b1;
               w_capture = ~r_we;
            end else if (err_i) begin
               w_done     = 1'b1;
               w_done_err = 1'b1;
            end else if (rty_i) begin
               if (r_retry < c_MAX_RTY) begin
                  w_cyc_nxt   = 1'b0;
                  w_stb_nxt   = 1'b0;
                  w_retry_nxt = r_retry + 1'b1;
                  w_state_nxt = BACKOFF;
               end else begin
                  w_done     = 1'b1;
                  w_done_err = 1'b1;
               end
            end else if (w_tmo_expired) begin
               w_done     = 1'b1;
               w_done_err = 1'b1;
            end else begin
               w_tmo_enable = 1'b1;
            end
         end
         BACKOFF: begin
            w_cyc_nxt   = 1'b1;
            w_stb_nxt   = 1'b1;
            w_tmo_clear = 1'b1;
            w_state_nxt = ACTIVE;
         end
         default: begin
            w_cyc_nxt   = 1'b0;
            w_stb_nxt   = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase

      if (w_done) begin
         w_cyc_nxt       = 1'b0;
         w_stb_nxt       = 1'b0;
         w_state_nxt     = IDLE;
         w_rsp_valid_nxt = 1'b1;
         w_rsp_err_nxt   = w_done_err;
         if (w_capture) begin
            w_rsp_dat_nxt = dat_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_cyc       <= 1'b0;
         r_stb       <= 1'b0;
         r_adr       <= '0;
         r_sel       <= '0;
         r_dat       <= '0;
         r_we        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_dat   <= '0;
         r_retry     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cyc       <= w_cyc_nxt;
         r_stb       <= w_stb_nxt;
         r_adr       <= w_adr_nxt;
         r_sel       <= w_sel_nxt;
         r_dat       <= w_dat_nxt;
         r_we        <= w_we_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
         r_rsp_dat   <= w_rsp_dat_nxt;
         r_retry     <= w_retry_nxt;
      end
   end

   assign req_ready_o = (r_state == IDLE);
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_err_o   = r_rsp_err;
   assign rsp_dat_o   = r_rsp_dat;
   // stb is only ever set together with cyc, so gating keeps the invariant explicit.
   assign cyc_o       = r_cyc;
   assign stb_o       = r_stb & r_cyc;
   assign adr_o       = r_adr;
   assign sel_o       = r_sel;
   assign dat_o       = r_dat;
   assign we_o        = r_we;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_master.sv
// ============================================================================
//  Module   : tb_wishbone_master
//  Purpose  : Directed scoreboard bench for wishbone_master with a flash-like slave.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wishbone_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_adr, req_dat;
   logic [3:0]  req_sel;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o, dat_i;
   logic [3:0]  sel;
   logic        ack, err, rty;

   // Slave model state
   logic        s_ack, s_err, s_rty;
   logic [31:0] mem [0:15];
   int          rty_given;
   int          rty_limit = 0;
   bit          silent    = 1'b0;
   bit          err_mode  = 1'b0;
   bit          f_term    = 1'b0;

   typedef struct packed {
      logic [31:0] dat;
      logic        err;
      logic        chk_dat;
   } exp_t;
   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign ack = s_ack | f_term;
   assign err = s_err | f_term;
   assign rty = s_rty | f_term;

   wishbone_master #(
      .MAX_RETRIES    (3),
      .TIMEOUT_CYCLES (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_adr_i   (req_adr),
      .req_sel_i   (req_sel),
      .req_dat_i   (req_dat),
      .rsp_valid_o (rsp_valid),
      .rsp_dat_o   (rsp_dat),
      .rsp_err_o   (rsp_err),
      .cyc_o       (cyc),
      .stb_o       (stb),
      .adr_o       (adr),
      .sel_o       (sel),
      .dat_o       (dat_o),
      .we_o        (we),
      .dat_i       (dat_i),
      .ack_i       (ack),
      .err_i       (err),
      .rty_i       (rty)
   );

   // Flash emulator: registered response one cycle after it sees stb.
   always @(posedge clk) begin
      if (rst) begin
         s_ack     <= 1'b0;
         s_err     <= 1'b0;
         s_rty     <= 1'b0;
         dat_i     <= '0;
         rty_given <= 0;
         for (int k = 0; k < 16; k++) mem[k] <= (k == 1) ? 32'hDEADBEEF : 32'h0;
      end else begin
         s_ack <= 1'b0;
         s_err <= 1'b0;
         s_rty <= 1'b0;
         if (cyc && stb && !s_ack && !s_err && !s_rty && !silent) begin
            if (rty_given < rty_limit) begin
               s_rty     <= 1'b1;
               rty_given <= rty_given + 1;
            end else if (err_mode) begin
               s_err <= 1'b1;
            end else begin
               s_ack <= 1'b1;
               dat_i <= mem[adr[3:0]];
               if (we) begin
                  for (int b = 0; b < 4; b++)
                     if (sel[b]) mem[adr[3:0]][8*b +: 8] <= dat_o[8*b +: 8];
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_txn(input logic we_r, input logic [31:0] adr_r, input logic [31:0] dat_r,
                         input logic [3:0] sel_r, input logic [31:0] exp_dat, input logic exp_err,
                         input logic chk_dat, output int cyc_hi, output int stb_rises,
                         output int gaps, output bit gap_bad, output bit hold_bad);
      exp_t        e;
      logic        prev_stb;
      int          cur_gap;
      bit          done;
      logic [31:0] exp_dato;
      exp_dato  = we_r ? dat_r : 32'h0;
      cyc_hi    = 0;
      stb_rises = 0;
      gaps      = 0;
      gap_bad   = 1'b0;
      hold_bad  = 1'b0;
      prev_stb  = 1'b0;
      cur_gap   = 0;
      done      = 1'b0;
      @(negedge clk);
      check("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we    = we_r;
      req_adr   = adr_r;
      req_dat   = dat_r;
      req_sel   = sel_r;
      e.dat     = exp_dat;
      e.err     = exp_err;
      e.chk_dat = chk_dat;
      sb_q.push_back(e);
      @(posedge clk);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_adr   = ~adr_r;
         req_dat   = ~dat_r;
         req_sel   = ~sel_r;
         req_we    = ~we_r;
         if (cyc) begin
            cyc_hi++;
            if (cur_gap > 0) begin
               gaps++;
               if (cur_gap != 1) gap_bad = 1'b1;
               cur_gap = 0;
            end
            if (adr !== adr_r || sel !== sel_r || we !== we_r || dat_o !== exp_dato) hold_bad = 1'b1;
         end else if (!rsp_valid) begin
            cur_gap++;
         end
         if (stb && !prev_stb) stb_rises++;
         if (stb && !cyc) hold_bad = 1'b1;
         prev_stb = stb;
         if (rsp_valid) begin
            done = 1'b1;
            check("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
               if (e.chk_dat) check("rsp_dat", rsp_dat, e.dat);
            end
         end
      end
      check("rsp_seen", {31'b0, done}, 32'd1);
      @(negedge clk);
      check("rsp_pulse_single", {31'b0, rsp_valid}, 32'd0);
   endtask

   int cyc_hi, stb_rises, gaps, pulses;
   bit gap_bad, hold_bad;

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_adr   = '0;
      req_dat   = '0;
      req_sel   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_cyc",       {31'b0, cyc},       32'd0);
      check("rst_stb",       {31'b0, stb},       32'd0);
      check("rst_ready",     {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_adr",       adr,                32'd0);
      check("rst_dat_o",     dat_o,              32'd0);
      check("rst_rsp_dat",   rsp_dat,            32'd0);

      // Read word 1
      rty_limit = rty_given;
      do_txn(1'b0, 32'd1, 32'hA5A5A5A5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("rd_cyc_cycles", 32'(cyc_hi), 32'd2);
      check("rd_stb_count",  32'(stb_rises), 32'd1);
      check("rd_hold",       {31'b0, hold_bad}, 32'd0);

      // Partial write, then read it back
      do_txn(1'b1, 32'd8, 32'h12345678, 4'b0011, 32'h0, 1'b0, 1'b0,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("wr_hold",       {31'b0, hold_bad}, 32'd0);
      check("wr_cyc_cycles", 32'(cyc_hi), 32'd2);
      do_txn(1'b0, 32'd8, 32'h0, 4'hF, 32'h00005678, 1'b0, 1'b1,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);

      // Two retries then ack
      rty_limit = rty_given + 2;
      do_txn(1'b0, 32'd1, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("rty2_stb_count", 32'(stb_rises), 32'd3);
      check("rty2_gaps",      32'(gaps), 32'd2);
      check("rty2_gap_len",   {31'b0, gap_bad}, 32'd0);
      check("rty2_hold",      {31'b0, hold_bad}, 32'd0);

      // Slave error: err flagged, read data left as before
      rty_limit = rty_given;
      err_mode  = 1'b1;
      do_txn(1'b0, 32'd8, 32'h0, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      err_mode  = 1'b0;

      // Retries exhausted
      rty_limit = rty_given + 4;
      do_txn(1'b0, 32'd2, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("rty4_attempts", 32'(stb_rises), 32'd4);
      check("rty4_gap_len",  {31'b0, gap_bad}, 32'd0);

      // Silent slave times out
      rty_limit = rty_given;
      silent    = 1'b1;
      do_txn(1'b0, 32'd3, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("tmo_cyc_cycles", 32'(cyc_hi), 32'd4);
      check("tmo_stb_count",  32'(stb_rises), 32'd1);

      // Terminations while idle must be ignored
      @(negedge clk);
      f_term = 1'b1;
      pulses = 0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid || cyc) pulses++;
      end
      f_term = 1'b0;
      @(negedge clk);
      if (rsp_valid || cyc) pulses++;
      check("idle_term_ignored", 32'(pulses), 32'd0);

      // Reset mid-ACTIVE aborts the transaction
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_adr   = 32'd1;
      req_sel   = 4'hF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_cyc_before", {31'b0, cyc}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("abort_cyc_after",   {31'b0, cyc},       32'd0);
      check("abort_ready_after", {31'b0, req_ready}, 32'd1);
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid) pulses++;
      end
      check("abort_no_rsp", 32'(pulses), 32'd0);
      silent = 1'b0;

      // Recovery read after reset
      rty_limit = rty_given;
      do_txn(1'b0, 32'd1, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1,
             cyc_hi, stb_rises, gaps, gap_bad, hold_bad);
      check("sb_empty_end", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
